pll_reset_sequencer: RTL and testbench

- Controls the clock generator PLL (125 MHz refclk in; 75 MHz and 10 MHz outputs) and sequences its reset and lock.
- Holds the PLL in reset for a minimum time, then waits for lock with a timeout and bounded retries.
- Releases the system reset only after lock has been stable for a qualification window.
- Re-runs the sequence on lock loss or on a software request. Runs entirely in the refclk domain; each consumer clock domain resynchronises sys_rst locally.

---
 rtl/pll_reset_sequencer.sv | 163 ++++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock sequencer: holds the PLL in reset, waits for lock with a timeout and retries, and
// qualifies lock stability before releasing the system reset. Runs entirely in the refclk domain.
module pll_reset_sequencer #(
  parameter int RST_HOLD_CYCLES     = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int MAX_RETRIES         = 3,
  parameter int CNT_W               = 17
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       relock_req,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       fail,
  output logic [1:0] retry_cnt,
  output logic [7:0] lock_loss_cnt
);

  typedef enum logic [2:0] {
    ST_HOLD,
    ST_WAIT_LOCK,
    ST_STABLE,
    ST_RUN,
    ST_FAIL
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [1:0]       RETRY_MAX    = 2'(MAX_RETRIES);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [1:0]       retry_q, retry_d;
  logic [7:0]       loss_q, loss_d;
  logic             sync1_q, lk_q;
  logic             pll_rst_q, pll_rst_d;
  logic             sys_rst_q, sys_rst_d;
  logic             ready_q, ready_d;
  logic             fail_q, fail_d;

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_HOLD;
      cnt_q     <= '0;
      retry_q   <= '0;
      loss_q    <= '0;
      sync1_q   <= 1'b0;
      lk_q      <= 1'b0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      loss_q    <= loss_d;
      sync1_q   <= pll_locked;
      lk_q      <= sync1_q;
      pll_rst_q <= pll_rst_d;
      sys_rst_q <= sys_rst_d;
      ready_q   <= ready_d;
      fail_q    <= fail_d;
    end
  end

  // Counter saturates rather than wrapping, so long stays in RUN/FAIL never alias a terminal count.
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_inc;
    retry_d = retry_q;
    loss_d  = loss_q;

    if (relock_req) begin
      state_d = ST_HOLD;
      cnt_d   = '0;
      retry_d = '0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end
        end
        ST_WAIT_LOCK: begin
          if (lk_q) begin
            state_d = ST_STABLE;
            cnt_d   = '0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            cnt_d = '0;
            if (retry_q == RETRY_MAX) begin
              state_d = ST_FAIL;
            end else begin
              state_d = ST_HOLD;
              retry_d = retry_q + 2'd1;
            end
          end
        end
        ST_STABLE: begin
          if (!lk_q) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = ST_RUN;
            cnt_d   = '0;
            retry_d = '0;
          end
        end
        ST_RUN: begin
          if (!lk_q) begin
            state_d = ST_HOLD;
            cnt_d   = '0;
            loss_d  = (&loss_q) ? loss_q : loss_q + 8'd1;
          end
        end
        ST_FAIL: begin
          state_d = ST_FAIL;
        end
        default: begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they switch on the same edge as the state register.
  always_comb begin
    pll_rst_d = 1'b0;
    sys_rst_d = 1'b1;
    ready_d   = 1'b0;
    fail_d    = 1'b0;
    case (state_d)
      ST_HOLD:      pll_rst_d = 1'b1;
      ST_WAIT_LOCK: pll_rst_d = 1'b0;
      ST_STABLE:    pll_rst_d = 1'b0;
      ST_RUN: begin
        sys_rst_d = 1'b0;
        ready_d   = 1'b1;
      end
      ST_FAIL: begin
        pll_rst_d = 1'b1;
        fail_d    = 1'b1;
      end
      default:      pll_rst_d = 1'b1;
    endcase
  end

  assign pll_rst       = pll_rst_q;
  assign sys_rst       = sys_rst_q;
  assign ready         = ready_q;
  assign fail          = fail_q;
  assign retry_cnt     = retry_q;
  assign lock_loss_cnt = loss_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed testbench for pll_reset_sequencer with small cycle parameters; expected output vectors
// are hand-computed in edges counted from each reset release or stimulus change.
module tb_pll_reset_sequencer;

  logic       refclk;
  logic       rst;
  logic       pll_locked;
  logic       relock_req;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic       fail;
  logic [1:0] retry_cnt;
  logic [7:0] lock_loss_cnt;

  int errors = 0;
  int checks = 0;

  pll_reset_sequencer #(
    .RST_HOLD_CYCLES(4),
    .LOCK_STABLE_CYCLES(8),
    .LOCK_TIMEOUT_CYCLES(16),
    .MAX_RETRIES(2),
    .CNT_W(17)
  ) dut (
    .refclk(refclk),
    .rst(rst),
    .pll_locked(pll_locked),
    .relock_req(relock_req),
    .pll_rst(pll_rst),
    .sys_rst(sys_rst),
    .ready(ready),
    .fail(fail),
    .retry_cnt(retry_cnt),
    .lock_loss_cnt(lock_loss_cnt)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  // Advance n rising edges and land 1 time unit past the last one, away from the active edge.
  task automatic applyStimulus(input int n);
    repeat (n) @(posedge refclk);
    #1;
  endtask

  // Compares every output at once against a hand-computed vector.
  task automatic checkOutput(input string tag, input logic e_pll_rst, input logic e_sys_rst,
                             input logic e_ready, input logic e_fail, input logic [1:0] e_retry,
                             input logic [7:0] e_loss);
    logic [13:0] observed;
    logic [13:0] expected;
    observed = {pll_rst, sys_rst, ready, fail, retry_cnt, lock_loss_cnt};
    expected = {e_pll_rst, e_sys_rst, e_ready, e_fail, e_retry, e_loss};
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed pll_rst/sys_rst/ready/fail=%b retry=%0d loss=%0d, expected pll_rst/sys_rst/ready/fail=%b retry=%0d loss=%0d",
             tag, observed[13:10], observed[9:8], observed[7:0],
             expected[13:10], expected[9:8], expected[7:0]);
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: time limit reached before the directed sequence ended");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    pll_locked = 1'b0;
    relock_req = 1'b0;
    applyStimulus(2);
    checkOutput("reset_values", 1, 1, 0, 0, 2'd0, 8'd0);
    rst = 1'b0;

    // Nominal bring-up: lock appears after edge 5, RUN at edge 16.
    applyStimulus(3);
    checkOutput("nominal_hold_edge3", 1, 1, 0, 0, 2'd0, 8'd0);
    applyStimulus(1);
    checkOutput("nominal_wait_edge4", 0, 1, 0, 0, 2'd0, 8'd0);
    applyStimulus(1);
    pll_locked = 1'b1;
    applyStimulus(10);
    checkOutput("nominal_stable_edge15", 0, 1, 0, 0, 2'd0, 8'd0);
    applyStimulus(1);
    checkOutput("nominal_run_edge16", 0, 0, 1, 0, 2'd0, 8'd0);

    // Lock loss in RUN for 3 cycles.
    pll_locked = 1'b0;
    applyStimulus(2);
    checkOutput("loss_still_run", 0, 0, 1, 0, 2'd0, 8'd0);
    applyStimulus(1);
    checkOutput("loss_hold_entry", 1, 1, 0, 0, 2'd0, 8'd1);
    pll_locked = 1'b1;
    applyStimulus(3);
    checkOutput("loss_hold_last", 1, 1, 0, 0, 2'd0, 8'd1);
    applyStimulus(1);
    checkOutput("loss_wait", 0, 1, 0, 0, 2'd0, 8'd1);
    applyStimulus(8);
    checkOutput("loss_stable_last", 0, 1, 0, 0, 2'd0, 8'd1);
    applyStimulus(1);
    checkOutput("loss_run_again", 0, 0, 1, 0, 2'd0, 8'd1);

    for (int i = 2; i <= 260; i++) begin
      pll_locked = 1'b0;
      applyStimulus(3);
      pll_locked = 1'b1;
      applyStimulus(13);
      if (i == 128) checkOutput("loss_count_128", 0, 0, 1, 0, 2'd0, 8'd128);
    end
    checkOutput("loss_count_saturated", 0, 0, 1, 0, 2'd0, 8'd255);

    // Asynchronous reset between edges while in RUN.
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_mid_run", 1, 1, 0, 0, 2'd0, 8'd0);
    pll_locked = 1'b0;
    applyStimulus(2);
    rst = 1'b0;

    // Glitchy lock: 5 high, 1 low, then high; STABLE aborts and restarts.
    applyStimulus(5);
    pll_locked = 1'b1;
    applyStimulus(5);
    pll_locked = 1'b0;
    applyStimulus(1);
    pll_locked = 1'b1;
    applyStimulus(5);
    checkOutput("glitch_no_early_run", 0, 1, 0, 0, 2'd0, 8'd0);
    applyStimulus(5);
    checkOutput("glitch_stable_last", 0, 1, 0, 0, 2'd0, 8'd0);
    applyStimulus(1);
    checkOutput("glitch_run", 0, 0, 1, 0, 2'd0, 8'd0);

    // Software relock from RUN, then asynchronous reset while in STABLE.
    relock_req = 1'b1;
    applyStimulus(1);
    checkOutput("relock_from_run", 1, 1, 0, 0, 2'd0, 8'd0);
    relock_req = 1'b0;
    applyStimulus(5);
    checkOutput("relock_in_stable", 0, 1, 0, 0, 2'd0, 8'd0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_mid_stable", 1, 1, 0, 0, 2'd0, 8'd0);
    pll_locked = 1'b0;
    applyStimulus(2);
    rst = 1'b0;

    // Lock never arrives: three attempts of 4+16 cycles, then FAIL at edge 60.
    applyStimulus(19);
    checkOutput("timeout_wait_edge19", 0, 1, 0, 0, 2'd0, 8'd0);
    applyStimulus(1);
    checkOutput("timeout_retry1_edge20", 1, 1, 0, 0, 2'd1, 8'd0);
    applyStimulus(20);
    checkOutput("timeout_retry2_edge40", 1, 1, 0, 0, 2'd2, 8'd0);
    applyStimulus(19);
    checkOutput("timeout_wait_edge59", 0, 1, 0, 0, 2'd2, 8'd0);
    applyStimulus(1);
    checkOutput("timeout_fail_edge60", 1, 1, 0, 1, 2'd2, 8'd0);
    applyStimulus(20);
    checkOutput("fail_persists", 1, 1, 0, 1, 2'd2, 8'd0);

    // Recovery from FAIL via relock_req with lock present.
    pll_locked = 1'b1;
    relock_req = 1'b1;
    applyStimulus(1);
    checkOutput("recover_hold", 1, 1, 0, 0, 2'd0, 8'd0);
    relock_req = 1'b0;
    applyStimulus(12);
    checkOutput("recover_stable_last", 0, 1, 0, 0, 2'd0, 8'd0);
    applyStimulus(1);
    checkOutput("recover_run", 0, 0, 1, 0, 2'd0, 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
